// File: rtl/apb_pkg.sv
// apb_pkg: shared state type and default geometry for the APB master.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/apb_wait_cnt.sv
// apb_wait_cnt: saturating wait-state counter with clear, enable and timeout flag.
module apb_wait_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en && cnt != W'(LIMIT)) cnt <= cnt + 1'b1;
    end
    // hit flags the stalled cycle whose increment brings the count to LIMIT
    assign hit = en && (cnt >= W'(LIMIT - 1));
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding command/response to APB bridge with wait-state timeout.
module apb_master import apb_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   paddr,
    output logic [2:0]          prot,
    output logic [DATA_W-1:0]   pwdata,
    output logic                pwrite,
    output logic                psel,
    output logic                penable,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic                slverr,
    input  logic [DATA_W-1:0]   prdata
);
    apb_state_t state, nxt;
    logic       hit;
    logic       take;
    logic       done;

    assign take = (state == IDLE) && cmd_valid;
    assign done = (state == ACCESS) && (pready || hit);

    apb_wait_cnt #(.LIMIT(TIMEOUT)) u_cnt (
        .clk (clk),
        .rst (nrst),
        .clr (take),
        .en  ((state == ACCESS) && !pready),
        .hit (hit)
    );

    always_ff @(posedge clk) begin
        if (nrst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt       = state;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) nxt = SETUP;
            end
            SETUP: begin
                psel = 1'b1;
                nxt  = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || hit) nxt = RESP;
            end
            default: begin
                rsp_valid = 1'b1;
                if (rsp_ready) nxt = IDLE;
            end
        endcase
    end

    // response registers load only when leaving ACCESS, so they hold through RESP
    always_ff @(posedge clk) begin
        if (nrst) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            prot      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (take) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_write ? cmd_wdata : '0;
                pstrb  <= cmd_write ? cmd_strb : '0;
                prot   <= cmd_prot;
            end
            if (done) begin
                rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                rsp_err   <= pready ? slverr : 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed and randomized transfers checked against a transaction-level model.
module tb_apb_master;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata = '0;
    logic [2:0]  prot;
    logic        pwrite, psel, penable, pready = 1'b0, slverr = 1'b0;
    logic [3:0]  pstrb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        err;
        int          hold;
    } xfer_t;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .prot(prot), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .pstrb(pstrb),
        .pready(pready), .slverr(slverr), .prdata(prdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // a transfer ends on the first ready cycle or after TO stalled cycles, whichever is first
    function automatic int exp_cycles(input xfer_t x);
        return (x.waits >= TO) ? TO : x.waits + 1;
    endfunction

    function automatic logic [32:0] exp_rsp(input xfer_t x);
        if (x.waits >= TO) return {1'b1, 32'h0};
        return {x.err, x.w ? 32'h0 : x.rdata};
    endfunction

    task automatic run(input xfer_t x);
        logic [32:0] e;
        int acc;
        e = exp_rsp(x);
        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = x.w;
        cmd_addr  = x.addr;
        cmd_wdata = x.wdata;
        cmd_strb  = x.strb;
        cmd_prot  = x.prot;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("busy_cmd_ready", cmd_ready, 0);
        acc = 0;
        for (int i = 0; i < TO + 8; i++) begin
            chk("paddr", paddr, x.addr);
            chk("pwrite", pwrite, x.w);
            chk("pwdata", pwdata, x.w ? x.wdata : 32'h0);
            chk("pstrb", pstrb, x.w ? x.strb : 4'h0);
            chk("prot", prot, x.prot);
            @(negedge clk);
            if (!penable) break;
            chk("access_psel", psel, 1);
            acc++;
            pready = (acc > x.waits);
            prdata = pready ? x.rdata : $urandom;
            slverr = pready ? x.err : 1'($urandom);
        end
        pready = 1'b0;
        slverr = 1'b0;
        chk("access_cycles", acc, exp_cycles(x));
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_psel", psel, 0);
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", rsp_err, e[32]);
        chk("rsp_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        for (int i = 0; i < x.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, e[31:0]);
            chk("hold_err", rsp_err, e[32]);
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid", rsp_valid, 0);
        chk("done_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        xfer_t x;
        repeat (3) @(negedge clk);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstrb", pstrb, 0);
        chk("rst_prot", prot, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        nrst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        run('{1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 4'hF, 3'd0, 0, 1'b0, 0});
        run('{1'b0, 32'h20, 32'h0, 32'h12345678, 4'hF, 3'd2, 3, 1'b0, 0});
        run('{1'b1, 32'h30, 32'hA5A5A5A5, 32'h0, 4'h3, 3'd1, 1, 1'b1, 1});
        run('{1'b0, 32'h40, 32'h0, 32'hFFFFFFFF, 4'h0, 3'd7, 100, 1'b0, 0});
        run('{1'b0, 32'h50, 32'h0, 32'hCAFEF00D, 4'h0, 3'd5, 15, 1'b1, 5});

        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h44;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_penable", penable, 1);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_penable", penable, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_paddr", paddr, 0);
        nrst = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_no_rsp", rsp_valid, 0);
        chk("mid_rst_no_setup", psel, 0);

        for (int n = 0; n < 40; n++) begin
            x.w     = 1'($urandom);
            x.addr  = $urandom;
            x.wdata = $urandom;
            x.rdata = $urandom;
            x.strb  = 4'($urandom);
            x.prot  = 3'($urandom);
            x.waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            x.err   = 1'($urandom);
            x.hold  = $urandom_range(0, 3);
            run(x);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: paddr/cmd_addr width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles with pready low before abort.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port nrst, input, 1: reset, synchronous and active-high (asserted = 1) despite the name.
REQ-006 SHALL have port cmd_valid, input, 1: command request.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr, input, ADDR_W: transfer address.
REQ-010 SHALL have port cmd_wdata, input, DATA_W: write data.
REQ-011 SHALL have port cmd_strb, input, DATA_W/8: byte strobes.
REQ-012 SHALL have port cmd_prot, input, 3: protection attributes.
REQ-013 SHALL have port rsp_valid, output, 1: response available.
REQ-014 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid and rsp_ready are both high.
REQ-015 SHALL have port rsp_rdata, output, DATA_W: read data (0 for writes).
REQ-016 SHALL have port rsp_err, output, 1: slverr or timeout.
REQ-017 SHALL have APB output ports paddr (ADDR_W), prot (3), pwdata (DATA_W), pwrite (1), psel (1), penable (1) and pstrb (DATA_W/8).
REQ-018 SHALL have APB input ports pready (1), slverr (1) and prdata (DATA_W).

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-020 IDLE: cmd_ready=1, psel=0, penable=0; on a cmd handshake, register addr/write/wdata/strb/prot and go to SETUP.
REQ-021 SETUP: psel=1, penable=0; APB outputs driven from the registered command; go to ACCESS unconditionally after 1 cycle.
REQ-022 ACCESS: psel=1, penable=1; APB outputs held stable; wait-state counter increments each cycle that pready=0.
REQ-023 ACCESS with pready=1: capture prdata (reads only; writes capture 0) and slverr into the response registers, then go to RESP.
REQ-024 ACCESS with pready=0 and the counter reaching TIMEOUT: go to RESP with rsp_err=1 and rsp_rdata=0; deassert psel/penable the next cycle.
REQ-025 RESP: rsp_valid=1, psel=0, penable=0, cmd_ready=0; on rsp_ready, go to IDLE.
REQ-026 cmd_ready SHALL be high only in IDLE, so one transfer is in flight at a time; minimum command-to-command spacing is 4 cycles with zero wait states and rsp_ready held high.
REQ-027 pwdata and pstrb SHALL be 0 for reads; pstrb SHALL equal cmd_strb for writes.
REQ-028 The wait-state counter SHALL clear on entry to SETUP and saturate rather than wrap.
REQ-029 slverr SHALL be sampled only when penable=1 and pready=1, and ignored otherwise.
REQ-030 rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-031 While nrst=1 at a clock edge: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, prot=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-032 After reset release, cmd_ready=1.
REQ-033 Reset in any state, including mid-ACCESS, SHALL abort the transfer with no response generated.

Structure
REQ-034 A shared package apb_pkg SHALL hold the state enum type apb_state_t and the default width/TIMEOUT constants.
REQ-035 A single sub-module apb_wait_cnt (saturating counter with clear, enable and a timeout flag) SHALL be instantiated.

Verification
REQ-036 The bench SHALL cover a write with addr 0x10, data 0xDEADBEEF, strb 0xF, pready=1 in ACCESS: psel rises 1 cycle after the handshake, penable 1 cycle later, and rsp_valid=1 with rsp_err=0 on the next cycle.
REQ-037 The bench SHALL cover a read of addr 0x20 with prdata=0x12345678 and 3 wait states: penable stays high for 4 cycles, then rsp_rdata=0x12345678.
REQ-038 The bench SHALL cover slverr=1 with pready=1 on a write: rsp_err=1.
REQ-039 The bench SHALL cover pready held at 0 with TIMEOUT=16: after 16 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0 and psel falls.
REQ-040 The bench SHALL cover rsp_ready held at 0 for 5 cycles: response stable, cmd_ready=0, and no new SETUP starts.
REQ-041 The bench SHALL cover nrst asserted during ACCESS: the next cycle shows psel=0, penable=0, rsp_valid=0 and cmd_ready=1 after release.
